// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction
//   fetch port (if_*) and the data load/store port (d_*) of the pipeline.
//   Data requests win over fetch requests. A store completes in its issue
//   cycle. A read completes LAT cycles after its issue cycle, with mem_rdata
//   passed straight through to the port in that completion cycle.
//
// Parameters
//   LAT        memory read latency in cycles, from mem_en to valid mem_rdata (1..15)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   if_req     fetch read request, held until if_ready
//   if_addr    fetch address, stable while if_req
//   if_rdata   fetch read data (last delivered value outside completion)
//   if_ready   one-cycle pulse, fetch complete
//   d_req      data request, held until d_ready
//   d_we       1 = store, 0 = load
//   d_addr     data address
//   d_wdata    store data
//   d_rdata    load data (last delivered value outside completion)
//   d_ready    one-cycle pulse, data transaction complete
//   mem_en     memory access strobe, one cycle per transaction
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid LAT cycles after mem_en
//   perf_if_wait / perf_d_wait  wait-cycle counters
//
// Build option
//   MEM_ARB_PERF_CNT_EN  when defined, perf_if_wait/perf_d_wait count the
//   cycles each port spends waiting (saturating). Otherwise both read 0.
//
// States
//   state   | meaning
//   IDLE    | memory free, arbitrating each cycle
//   ISSUE_I | mem_en cycle of a fetch
//   ISSUE_D | mem_en cycle of a load or store (store completes here)
//   WAIT_I  | fetch read in flight; completes when if_ready is high
//   WAIT_D  | load read in flight; completes when d_ready is high

module mem_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] perf_if_wait,
  output logic [31:0] perf_d_wait
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_I,
    ISSUE_D,
    WAIT_I,
    WAIT_D
  } state_t;

  // Down-counter reload: cycles remaining after the issue cycle before the
  // ready flag is raised for the completion cycle.
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t      state;
  logic [3:0]  lat_cnt;
  logic [31:0] if_hold;
  logic [31:0] d_hold;

  logic done_i;
  logic done_rd_d;
  logic done_st_d;
  logic arbitrate;
  logic grant_d;
  logic grant_i;

  // Completion cycles. The ready flags are registered one cycle ahead, so a
  // read completes in the WAIT cycle where its ready is already high. A store
  // completes in its own issue cycle, recognised by the registered mem_we.
  always_comb begin
    done_i    = (state == WAIT_I) && if_ready;
    done_rd_d = (state == WAIT_D) && d_ready;
    done_st_d = (state == ISSUE_D) && mem_we;
    arbitrate = (state == IDLE) || done_i || done_rd_d || done_st_d;
    // The completing port still holds its req this cycle; exclude it.
    grant_d   = arbitrate && d_req && !(done_rd_d || done_st_d);
    grant_i   = arbitrate && !grant_d && if_req && !done_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_hold   <= '0;
      d_hold    <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;

      if (done_i) begin
        if_hold <= mem_rdata;
      end
      if (done_rd_d) begin
        d_hold <= mem_rdata;
      end

      case (state)
        ISSUE_I: begin
          state   <= WAIT_I;
          lat_cnt <= LAT_M1;
          if (LAT_M1 == 4'd0) begin
            if_ready <= 1'b1;
          end
        end
        ISSUE_D: begin
          if (!mem_we) begin
            state   <= WAIT_D;
            lat_cnt <= LAT_M1;
            if (LAT_M1 == 4'd0) begin
              d_ready <= 1'b1;
            end
          end
        end
        WAIT_I: begin
          if (!if_ready) begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) begin
              if_ready <= 1'b1;
            end
          end
        end
        WAIT_D: begin
          if (!d_ready) begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) begin
              d_ready <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase

      // Arbitration overrides the per-state progression in completion cycles.
      if (arbitrate) begin
        if (grant_d) begin
          state     <= ISSUE_D;
          mem_en    <= 1'b1;
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_we ? d_wdata : 32'h0;
          d_ready   <= d_we;
        end else if (grant_i) begin
          state    <= ISSUE_I;
          mem_en   <= 1'b1;
          mem_addr <= if_addr;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  assign if_rdata = done_i ? mem_rdata : if_hold;
  assign d_rdata  = done_rd_d ? mem_rdata : d_hold;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_cnt;
  logic [31:0] perf_d_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_cnt <= '0;
      perf_d_cnt  <= '0;
    end else begin
      if (if_req && !if_ready && (perf_if_cnt != 32'hFFFF_FFFF)) begin
        perf_if_cnt <= perf_if_cnt + 32'd1;
      end
      if (d_req && !d_ready && (perf_d_cnt != 32'hFFFF_FFFF)) begin
        perf_d_cnt <= perf_d_cnt + 32'd1;
      end
    end
  end

  assign perf_if_wait = perf_if_cnt;
  assign perf_d_wait  = perf_d_cnt;
`else
  assign perf_if_wait = 32'h0;
  assign perf_d_wait  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

`ifdef MEM_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  int          errors;
  int          checks;

  // instance a: LAT = 2
  logic        if_req, if_ready, d_req, d_we, d_ready, mem_en, mem_we;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, perf_if_wait, perf_d_wait;

  // instance b: LAT = 1
  logic        b_if_req, b_if_ready, b_d_req, b_d_we, b_d_ready, b_mem_en, b_mem_we;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata, b_perf_if_wait, b_perf_d_wait;

  mem_arbiter #(.LAT(LAT)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
  );

  mem_arbiter #(.LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .perf_if_wait(b_perf_if_wait), .perf_d_wait(b_perf_d_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memories for the randomized run: one seen by the memory driver, one by the model
  logic [31:0] drv_mem [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] sched   [int];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0; b_mem_rdata = 0;
  endtask

  // leaves the bench at cycle 0 after release: inputs set now are sampled at the next edge
  task automatic do_reset();
    rst = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    zero_inputs();
    #2;
    rst = 1'b0;
    mem_rdata = 32'hFFFF_0000; b_mem_rdata = 32'h0000_FFFF;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got=%h exp=0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%h exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready got=%h exp=0", if_ready); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got=%h exp=0", d_ready); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
    checks++; if (perf_if_wait !== 32'h0) begin errors++; $display("FAIL rst_perf_if got=%h exp=0", perf_if_wait); end
    checks++; if (perf_d_wait !== 32'h0) begin errors++; $display("FAIL rst_perf_d got=%h exp=0", perf_d_wait); end
    checks++; if (b_if_rdata !== 32'h0) begin errors++; $display("FAIL rst_b_if_rdata got=%h exp=0", b_if_rdata); end
    // requests seen while reset is held must not issue
    if_req = 1; if_addr = 32'h44; d_req = 1; d_addr = 32'h88;
    repeat (3) begin
      next_cycle();
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_held_mem_en got=%h exp=0", mem_en); end
    end
    zero_inputs();
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req = 1; if_addr = 32'h100;                                        // cycle 0
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL f_c0_mem_en got=%h exp=0", mem_en); end
    next_cycle(); #1;                                                     // cycle 1
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL f_c1_mem_en got=%h exp=1", mem_en); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL f_c1_addr got=%h exp=100", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL f_c1_we got=%h exp=0", mem_we); end
    next_cycle(); #1;                                                     // cycle 2
    checks++; if (mem_en !== 1'b0 || if_ready !== 1'b0) begin errors++; $display("FAIL f_c2_idle got en=%h rdy=%h exp=0/0", mem_en, if_ready); end
    next_cycle(); mem_rdata = 32'hDEAD_BEEF; #1;                         // cycle 3
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL f_c3_ready got=%h exp=1", if_ready); end
    checks++; if (if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL f_c3_rdata got=%h exp=deadbeef", if_rdata); end
    next_cycle(); if_req = 0; mem_rdata = 32'h1357_9BDF; #1;             // cycle 4
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL f_c4_ready got=%h exp=0", if_ready); end
    checks++; if (if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL f_c4_hold got=%h exp=deadbeef", if_rdata); end
  endtask

  task automatic test_store_and_fetch();
    do_reset();
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
    next_cycle(); #1;                                                     // cycle 1
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sf_c1_en_we got=%h/%h exp=1/1", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h80) begin errors++; $display("FAIL sf_c1_addr got=%h exp=80", mem_addr); end
    checks++; if (mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL sf_c1_wdata got=%h exp=12345678", mem_wdata); end
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL sf_c1_d_ready got=%h exp=1", d_ready); end
    next_cycle(); d_req = 0; d_we = 0; #1;                                // cycle 2
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL sf_c2_fetch got en=%h addr=%h exp=1/200", mem_en, mem_addr); end
    checks++; if (mem_we !== 1'b0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL sf_c2_we got=%h wdata=%h exp=0/0", mem_we, mem_wdata); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL sf_c2_d_ready got=%h exp=0", d_ready); end
    next_cycle(); #1;                                                     // cycle 3
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL sf_c3_if_ready got=%h exp=0", if_ready); end
    next_cycle(); mem_rdata = 32'hCAFE_F00D; #1;                         // cycle 4
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sf_c4_fetch got rdy=%h data=%h exp=1/cafef00d", if_ready, if_rdata); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL sf_c4_d_rdata got=%h exp=0", d_rdata); end
    next_cycle(); if_req = 0; #1;                                         // cycle 5
    checks++; if (perf_d_wait !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL sf_perf_d got=%0d exp=%0d", perf_d_wait, PERF ? 1 : 0); end
    checks++; if (perf_if_wait !== (PERF ? 32'd4 : 32'd0)) begin errors++; $display("FAIL sf_perf_if got=%0d exp=%0d", perf_if_wait, PERF ? 4 : 0); end
  endtask

  task automatic test_back_to_back();
    int en_cyc[$];
    int rdy_cyc[$];
    logic [31:0] got_data[$];
    do_reset();
    if_req = 1; if_addr = 32'h0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      if (c == 3) mem_rdata = 32'h1111_1111;
      else if (c == 7) mem_rdata = 32'h2222_2222;
      else mem_rdata = $urandom;
      if (c == 4) if_addr = 32'h4;
      if (c == 8) if_req = 0;
      #1;
      if (mem_en === 1'b1) en_cyc.push_back(c);
      if (if_ready === 1'b1) begin rdy_cyc.push_back(c); got_data.push_back(if_rdata); end
      if (c == 5) begin
        checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL b2b_addr2 got=%h exp=4", mem_addr); end
      end
    end
    checks++; if (en_cyc.size() != 2 || en_cyc[0] != 1 || en_cyc[1] != 5) begin errors++; $display("FAIL b2b_mem_en_cycles got n=%0d exp cycles 1,5", en_cyc.size()); end
    checks++; if (rdy_cyc.size() != 2 || rdy_cyc[0] != 3 || rdy_cyc[1] != 7) begin errors++; $display("FAIL b2b_ready_cycles got n=%0d exp cycles 3,7", rdy_cyc.size()); end
    checks++; if (got_data.size() != 2 || got_data[0] !== 32'h1111_1111 || got_data[1] !== 32'h2222_2222) begin errors++; $display("FAIL b2b_rdata got n=%0d exp 11111111,22222222", got_data.size()); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h40;                                 // cycle 0
    next_cycle(); #1;                                                     // cycle 1
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL ri_c1_issue got en=%h addr=%h exp=1/40", mem_en, mem_addr); end
    next_cycle(); rst = 0; d_req = 0; #1;                                 // cycle 2
    checks++; if (mem_en !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL ri_c2_rst got en=%h rdy=%h exp=0/0", mem_en, d_ready); end
    next_cycle(); mem_rdata = 32'hAA; #1;                                 // cycle 3
    checks++; if (d_ready !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL ri_c3 got rdy=%h data=%h exp=0/0", d_ready, d_rdata); end
    next_cycle(); rst = 1; #1;                                            // cycle 4
    checks++; if (d_ready !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL ri_c4 got rdy=%h data=%h exp=0/0", d_ready, d_rdata); end
    next_cycle(); d_req = 1; d_addr = 32'h40; #1;                         // cycle 5
    checks++; if (mem_en !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL ri_c5 got en=%h rdy=%h exp=0/0", mem_en, d_ready); end
    next_cycle(); mem_rdata = 32'h0; #1;                                  // cycle 6
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin errors++; $display("FAIL ri_c6_reissue got en=%h addr=%h we=%h exp=1/40/0", mem_en, mem_addr, mem_we); end
    next_cycle(); #1;                                                     // cycle 7
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL ri_c7_ready got=%h exp=0", d_ready); end
    next_cycle(); mem_rdata = 32'h77; #1;                                 // cycle 8
    checks++; if (d_ready !== 1'b1 || d_rdata !== 32'h77) begin errors++; $display("FAIL ri_c8_load got rdy=%h data=%h exp=1/77", d_ready, d_rdata); end
    next_cycle(); d_req = 0; #1;
  endtask

  task automatic test_lat1();
    do_reset();
    b_d_req = 1; b_d_we = 0; b_d_addr = 32'h10;                           // cycle 0
    next_cycle(); b_if_req = 1; b_if_addr = 32'h300; #1;                  // cycle 1
    checks++; if (b_mem_en !== 1'b1 || b_mem_addr !== 32'h10) begin errors++; $display("FAIL l1_c1_issue got en=%h addr=%h exp=1/10", b_mem_en, b_mem_addr); end
    next_cycle(); b_mem_rdata = 32'h55; #1;                               // cycle 2
    checks++; if (b_d_ready !== 1'b1 || b_d_rdata !== 32'h55) begin errors++; $display("FAIL l1_c2_load got rdy=%h data=%h exp=1/55", b_d_ready, b_d_rdata); end
    checks++; if (b_mem_en !== 1'b0) begin errors++; $display("FAIL l1_c2_mem_en got=%h exp=0", b_mem_en); end
    next_cycle(); b_d_req = 0; b_mem_rdata = 32'h9; #1;                   // cycle 3
    checks++; if (b_mem_en !== 1'b1 || b_mem_addr !== 32'h300) begin errors++; $display("FAIL l1_c3_fetch got en=%h addr=%h exp=1/300", b_mem_en, b_mem_addr); end
    checks++; if (b_d_rdata !== 32'h55) begin errors++; $display("FAIL l1_c3_hold got=%h exp=55", b_d_rdata); end
    next_cycle(); b_mem_rdata = 32'h66; #1;                               // cycle 4
    checks++; if (b_if_ready !== 1'b1 || b_if_rdata !== 32'h66) begin errors++; $display("FAIL l1_c4_fetch got rdy=%h data=%h exp=1/66", b_if_ready, b_if_rdata); end
    next_cycle(); b_if_req = 0; #1;
  endtask

  // Transaction-level reference: who holds the memory, when it was issued and
  // when it completes, with arbitration decided from the request lines.
  task automatic test_random(input int ncyc);
    int busy, issue_at, done_at, perf_i, perf_d;
    logic pc_i, pc_d, comp_i, comp_d, x_en, x_we, m_we;
    logic [31:0] m_addr, m_wdata, x_addr, x_wdata, rd, e_ir, e_dr, h_i, h_d, e_pi, e_pd;
    drv_mem.delete(); exp_mem.delete(); sched.delete();
    busy = 0; issue_at = -1; done_at = -1; perf_i = 0; perf_d = 0;
    pc_i = 0; pc_d = 0; m_we = 0; m_addr = 0; m_wdata = 0; h_i = 0; h_d = 0;
    do_reset();
    for (int t = 0; t < ncyc; t++) begin
      if (t > 0) next_cycle();
      if (pc_i) if_req = 0;
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1; if_addr = 32'($urandom_range(0, 31)) << 2;
      end
      if (pc_d) begin d_req = 0; d_we = 0; end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = 32'($urandom_range(0, 31)) << 2; d_wdata = $urandom;
      end
      if (mem_en === 1'b1) begin
        if (mem_we === 1'b1) drv_mem[mem_addr] = mem_wdata;
        else sched[t + LAT] = drv_mem.exists(mem_addr) ? drv_mem[mem_addr] : init_val(mem_addr);
      end
      mem_rdata = sched.exists(t) ? sched[t] : $urandom;
      #1;
      x_en    = (busy != 0) && (t == issue_at);
      x_we    = x_en && m_we;
      x_addr  = x_en ? m_addr : 32'h0;
      x_wdata = x_we ? m_wdata : 32'h0;
      comp_i  = (busy == 1) && (t == done_at);
      comp_d  = (busy == 2) && (t == done_at);
      rd      = exp_mem.exists(m_addr) ? exp_mem[m_addr] : init_val(m_addr);
      e_ir    = comp_i ? rd : h_i;
      e_dr    = (comp_d && !m_we) ? rd : h_d;
      e_pi    = PERF ? 32'(perf_i) : 32'h0;
      e_pd    = PERF ? 32'(perf_d) : 32'h0;
      checks++; if (mem_en !== x_en) begin errors++; $display("FAIL rnd_mem_en t=%0d got=%h exp=%h", t, mem_en, x_en); end
      checks++; if (mem_we !== x_we) begin errors++; $display("FAIL rnd_mem_we t=%0d got=%h exp=%h", t, mem_we, x_we); end
      checks++; if (mem_addr !== x_addr) begin errors++; $display("FAIL rnd_mem_addr t=%0d got=%h exp=%h", t, mem_addr, x_addr); end
      checks++; if (mem_wdata !== x_wdata) begin errors++; $display("FAIL rnd_mem_wdata t=%0d got=%h exp=%h", t, mem_wdata, x_wdata); end
      checks++; if (if_ready !== comp_i) begin errors++; $display("FAIL rnd_if_ready t=%0d got=%h exp=%h", t, if_ready, comp_i); end
      checks++; if (d_ready !== comp_d) begin errors++; $display("FAIL rnd_d_ready t=%0d got=%h exp=%h", t, d_ready, comp_d); end
      checks++; if (if_rdata !== e_ir) begin errors++; $display("FAIL rnd_if_rdata t=%0d got=%h exp=%h", t, if_rdata, e_ir); end
      checks++; if (d_rdata !== e_dr) begin errors++; $display("FAIL rnd_d_rdata t=%0d got=%h exp=%h", t, d_rdata, e_dr); end
      checks++; if (perf_if_wait !== e_pi) begin errors++; $display("FAIL rnd_perf_if t=%0d got=%0d exp=%0d", t, perf_if_wait, e_pi); end
      checks++; if (perf_d_wait !== e_pd) begin errors++; $display("FAIL rnd_perf_d t=%0d got=%0d exp=%0d", t, perf_d_wait, e_pd); end
      if (comp_d && m_we) exp_mem[m_addr] = m_wdata;
      h_i = e_ir; h_d = e_dr;
      if (if_req && !comp_i) perf_i++;
      if (d_req && !comp_d) perf_d++;
      if (busy == 0 || t == done_at) begin
        if (d_req && !comp_d) begin
          busy = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
          issue_at = t + 1; done_at = d_we ? t + 1 : t + 1 + LAT;
        end else if (if_req && !comp_i) begin
          busy = 1; m_we = 0; m_addr = if_addr; m_wdata = 0;
          issue_at = t + 1; done_at = t + 1 + LAT;
        end else begin
          busy = 0;
        end
      end
      pc_i = comp_i; pc_d = comp_d;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    zero_inputs();
    test_reset();
    test_fetch_only();
    test_store_and_fetch();
    test_back_to_back();
    test_reset_inflight();
    test_lat1();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the instruction-fetch port and the data load/store port of the combined ARM/RISC-V 5-stage pipeline.
- Sits between stage_f/stage_m and the memory macro.
- Its ready outputs feed the hazard unit, which stalls F or M while a port waits.

Parameters:
- LAT, 2: memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- if_req  in  1  fetch read request; held high until if_ready
- if_addr  in  32  fetch address; stable while if_req
- if_rdata  out  32  fetch read data
- if_ready  out  1  one-cycle pulse, fetch transaction complete
- d_req  in  1  data request; held high until d_ready
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data
- d_ready  out  1  one-cycle pulse, data transaction complete
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid LAT cycles after mem_en
- perf_if_wait  out  32  fetch wait-cycle counter
- perf_d_wait  out  32  data wait-cycle counter

Behaviour:
- FSM states: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D. A 4-bit latency counter counts the cycles since mem_en.
- Grant decision is made in IDLE, or in any completion cycle.
  - Priority: data over fetch. Data is the older instruction.
  - In a completion cycle, the port being completed is excluded from arbitration, because its req is still high that cycle.
  - If nothing is eligible, go to IDLE.
- A grant at cycle T gives ISSUE at T+1 (cycle C). In C:
  - mem_en=1.
  - mem_addr is the granted port's address.
  - mem_we = d_we for data, 0 for fetch.
  - mem_wdata = d_wdata for data, 0 for fetch.
- Outside C: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Store: d_ready=1 in cycle C itself. C is the completion cycle.
- Read (fetch or load): WAIT until cycle C+LAT. That is the completion cycle:
  - x_ready=1.
  - x_rdata = mem_rdata, combinational pass-through.
  - mem_rdata is captured into a hold register at the end of C+LAT.
- Outside completion cycles, each x_rdata shows its last delivered value.
- A port's ready is never asserted without a prior grant. Exactly one ready pulse per transaction.
- Back-to-back transactions:
  - Data then fetch: no bubble.
  - Fetch then data: no bubble.
  - Same port twice: one IDLE bubble.
- Requests that appear during ISSUE/WAIT are held by the requester and arbitrated at completion.
- Latencies with LAT=2, request seen in IDLE at T:
  - Store complete at T+1.
  - Read complete at T+3.
- Reset:
  - Async assertion at any time forces IDLE and counter=0.
  - Outputs: all ready=0, mem_*=0, if_rdata=0, d_rdata=0, perf counters=0.
  - An in-flight read is abandoned. mem_rdata arriving after reset release is ignored.
- No transaction is issued in the cycle reset deasserts unless a req is sampled in that IDLE cycle. It is then issued the next cycle.
- Protocol violations (req dropped before ready) are undefined. They are not checked.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined:
  - perf_if_wait increments every cycle with if_req=1 && if_ready=0.
  - perf_d_wait increments every cycle with d_req=1 && d_ready=0.
  - Both counters saturate at 0xFFFFFFFF and are cleared by reset.
- When not defined: both ports remain present and are tied to 0. No counter flops are synthesised.

Test Plan:
1. LAT=2, fetch-only. if_req at cycle 0 with if_addr=0x100; memory returns 0xDEADBEEF at cycle 3 -> mem_en=1/mem_addr=0x100 at cycle 1, if_ready=1 with if_rdata=0xDEADBEEF at cycle 3, if_rdata still 0xDEADBEEF at cycle 4.
2. if_req(0x200) and d_req store (0x80, 0x12345678) both at cycle 0 -> store issued cycle 1 with mem_we=1 and d_ready=1 at cycle 1; fetch mem_en at cycle 2; if_ready at cycle 4.
3. Two consecutive fetches (0x0 then 0x4, req held continuously) -> mem_en at cycles 1 and 5, if_ready at cycles 3 and 7, IDLE at cycle 4.
4. Load at 0x40 issued at cycle 1; rst pulled low at cycle 2 and released at cycle 4; memory drives 0xAA at cycle 3 -> d_ready never pulses, d_rdata=0, re-request at cycle 5 issues at cycle 6.
5. MEM_ARB_PERF_CNT_EN defined, scenario 2 -> perf_d_wait=1, perf_if_wait=4. Undefined -> both 0.
6. LAT=1 load at 0x10 with d_req at cycle 0, mem_rdata=0x55 at cycle 2 -> d_ready and d_rdata=0x55 at cycle 2; fetch pending from cycle 1 is granted at cycle 2 and issued at cycle 3.
